// File: rtl/pe_packet_injector.sv
// PE-side NoC injector: builds packets, queues them in a FIFO and
// dispatches each head to the router PE port or the local loopback port.
module pe_packet_injector #(
  parameter int         WIDTH = 31,
  parameter logic [1:0] XADDR = 2'd0,
  parameter logic [1:0] YADDR = 2'd0,
  parameter int         DEPTH = 4,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_xdest,
  input  logic [1:0]       in_ydest,
  input  logic [WIDTH-9:0] in_payload,
  output logic             net_valid,
  input  logic             net_ready,
  output logic [WIDTH-1:0] net_pkt,
  output logic             loop_valid,
  input  logic             loop_ready,
  output logic [WIDTH-1:0] loop_pkt,
  output logic [CNT_W-1:0] net_cnt,
  output logic [CNT_W-1:0] loop_cnt
);

  localparam int PW = WIDTH - 8;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic [WIDTH-1:0] in_pkt;
  logic [WIDTH-1:0] head;
  logic             head_loop;
  logic             fifo_ne;
  logic             push;
  logic             pop;
  logic             net_acc;
  logic             loop_acc;
  logic             accept;

  assign in_pkt    = {XADDR, YADDR, in_xdest, in_ydest, in_payload};
  assign head      = mem[rptr];
  assign head_loop = (head[PW+3:PW+2] == XADDR) &&
                     (head[PW+1:PW] == YADDR);
  assign fifo_ne   = (count != '0);
  assign push      = in_valid && in_ready;
  assign net_acc   = net_valid && net_ready;
  assign loop_acc  = loop_valid && loop_ready;
  assign accept    = net_acc || loop_acc;
  // The output register refills whenever it is empty or just drained.
  assign pop       = fifo_ne && ((state == IDLE) || accept);

  // Next occupancy from this cycle's enqueue/dequeue pair.
  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Packet storage; stale entries are discarded by the pointer reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_pkt;
  end

  // Pointers, occupancy, output FSM and delivery counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      in_ready   <= 1'b0;
      state      <= IDLE;
      net_valid  <= 1'b0;
      loop_valid <= 1'b0;
      net_pkt    <= '0;
      loop_pkt   <= '0;
      net_cnt    <= '0;
      loop_cnt   <= '0;
    end else begin
      count    <= count_nxt;
      in_ready <= (count_nxt != FULL);
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (net_acc)  net_cnt  <= net_cnt + 1'b1;
      if (loop_acc) loop_cnt <= loop_cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (pop) begin
            state      <= SEND;
            net_valid  <= !head_loop;
            loop_valid <= head_loop;
            net_pkt    <= head_loop ? '0 : head;
            loop_pkt   <= head_loop ? head : '0;
          end
        end
        SEND: begin
          if (pop) begin
            net_valid  <= !head_loop;
            loop_valid <= head_loop;
            net_pkt    <= head_loop ? '0 : head;
            loop_pkt   <= head_loop ? head : '0;
          end else if (accept) begin
            state      <= IDLE;
            net_valid  <= 1'b0;
            loop_valid <= 1'b0;
            net_pkt    <= '0;
            loop_pkt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_onehot: assert property (@(posedge clk) disable iff (rst)
    !(net_valid && loop_valid));

  a_net_hold: assert property (@(posedge clk) disable iff (rst)
    (net_valid && !net_ready) |=> $stable(net_pkt));

  a_loop_hold: assert property (@(posedge clk) disable iff (rst)
    (loop_valid && !loop_ready) |=> $stable(loop_pkt));

  a_count: assert property (@(posedge clk)
    count <= FULL);

endmodule

// File: tb/tb_pe_packet_injector.sv
// Directed bench for pe_packet_injector at node (1,2), DEPTH=4,
// 4-bit counters so that wrap-around is reachable quickly.
module tb_pe_packet_injector;

  localparam int WIDTH = 31;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_xdest;
  logic [1:0]       in_ydest;
  logic [22:0]      in_payload;
  logic             net_valid;
  logic             net_ready;
  logic [30:0]      net_pkt;
  logic             loop_valid;
  logic             loop_ready;
  logic [30:0]      loop_pkt;
  logic [CNT_W-1:0] net_cnt;
  logic [CNT_W-1:0] loop_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int acc     = 0;
  logic [22:0] seen [$];

  pe_packet_injector #(
    .WIDTH(WIDTH),
    .XADDR(2'd1),
    .YADDR(2'd2),
    .DEPTH(4),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_xdest(in_xdest),
    .in_ydest(in_ydest),
    .in_payload(in_payload),
    .net_valid(net_valid),
    .net_ready(net_ready),
    .net_pkt(net_pkt),
    .loop_valid(loop_valid),
    .loop_ready(loop_ready),
    .loop_pkt(loop_pkt),
    .net_cnt(net_cnt),
    .loop_cnt(loop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Delivered payloads in handshake order.
  always @(posedge clk) begin
    if (!rst && net_valid && net_ready) seen.push_back(net_pkt[22:0]);
    if (!rst && loop_valid && loop_ready) seen.push_back(loop_pkt[22:0]);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] xd, input logic [1:0] yd,
                      input logic [22:0] pl);
    in_valid   = 1'b1;
    in_xdest   = xd;
    in_ydest   = yd;
    in_payload = pl;
    if (in_ready) acc++;
    tick();
  endtask

  initial begin
    logic [30:0] exp_pkt;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_xdest   = '0;
    in_ydest   = '0;
    in_payload = '0;
    net_ready  = 1'b0;
    loop_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_net_valid", net_valid, 0);
    chk("rst_loop_valid", loop_valid, 0);
    chk("rst_net_pkt", net_pkt, 0);
    chk("rst_cnts", {net_cnt, loop_cnt}, 0);
    rst = 1'b0;
    tick();
    chk("rst_release_ready", in_ready, 1);

    // Basic net path with 2-edge latency.
    net_ready = 1'b1;
    send(2'd3, 2'd0, 23'h00ABC);
    in_valid = 1'b0;
    chk("lat_edge1_valid", net_valid, 0);
    tick();
    exp_pkt = {2'd1, 2'd2, 2'd3, 2'd0, 23'h00ABC};
    chk("net_valid", net_valid, 1);
    chk("net_pkt", net_pkt, exp_pkt);
    chk("net_no_loop", loop_valid, 0);
    tick();
    chk("net_cnt1", net_cnt, 1);
    chk("net_drop_valid", net_valid, 0);

    // Loopback with a one-cycle stall.
    net_ready = 1'b0;
    send(2'd1, 2'd2, 23'h5);
    in_valid = 1'b0;
    tick();
    chk("loop_valid", loop_valid, 1);
    chk("loop_no_net", net_valid, 0);
    chk("loop_dest", loop_pkt[26:23], 4'b0110);
    tick();
    chk("loop_hold", loop_valid, 1);
    chk("loop_hold_pl", loop_pkt[22:0], 23'h5);
    loop_ready = 1'b1;
    tick();
    loop_ready = 1'b0;
    chk("loop_cnt1", loop_cnt, 1);
    chk("loop_drop", loop_valid, 0);
    chk("loop_net_cnt", net_cnt, 1);

    // Fill: 4 in FIFO + 1 in the output register.
    acc = 0;
    for (int i = 0; i < 6; i++) send(2'd3, 2'd3, 23'(32'h10 + i));
    in_valid = 1'b0;
    chk("full_accepts", acc, 5);
    chk("full_in_ready", in_ready, 0);
    net_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("drain_valid", net_valid, 1);
      chk("drain_pl", net_pkt[22:0], 32'h10 + k);
      tick();
    end
    chk("drain_empty", net_valid, 0);
    chk("drain_in_ready", in_ready, 1);
    chk("drain_cnt", net_cnt, 6);

    // Head-of-line: A net, B loop, C net.
    seen.delete();
    loop_ready = 1'b0;
    send(2'd3, 2'd1, 23'hA);
    send(2'd1, 2'd2, 23'hB);
    send(2'd0, 2'd0, 23'hC);
    in_valid = 1'b0;
    tick();
    tick();
    chk("hol_loop_stall", loop_valid, 1);
    chk("hol_net_blocked", net_valid, 0);
    chk("hol_loop_pl", loop_pkt[22:0], 23'hB);
    loop_ready = 1'b1;
    tick();
    loop_ready = 1'b0;
    chk("hol_c_valid", net_valid, 1);
    chk("hol_c_pl", net_pkt[22:0], 23'hC);
    tick();
    chk("hol_n", seen.size(), 3);
    if (seen.size() == 3) begin
      chk("hol_ord0", seen[0], 23'hA);
      chk("hol_ord1", seen[1], 23'hB);
      chk("hol_ord2", seen[2], 23'hC);
    end

    // Mid-stream reset discards everything.
    net_ready = 1'b0;
    send(2'd3, 2'd0, 23'h21);
    send(2'd3, 2'd0, 23'h22);
    send(2'd3, 2'd0, 23'h23);
    in_valid  = 1'b0;
    net_ready = 1'b1;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_net_valid", net_valid, 0);
    chk("mrst_loop_valid", loop_valid, 0);
    chk("mrst_cnts", {net_cnt, loop_cnt}, 0);
    chk("mrst_in_ready", in_ready, 0);
    seen.delete();
    tick();
    chk("mrst_ready_back", in_ready, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("mrst_no_pkts", seen.size(), 0);
    chk("mrst_idle", net_valid, 0);

    // Counter wrap: 17 packets on a 4-bit counter.
    acc = 0;
    for (int i = 0; i < 17; i++) send(2'd0, 2'd1, 23'(i));
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("wrap_accepts", acc, 17);
    chk("wrap_cnt", net_cnt, 1);
    chk("wrap_idle", net_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_packet_injector.md
Name: pe_packet_injector

Overview:
- Clocked PE-side network interface. It forms 31-bit NoC packets from PE spike/partial-sum requests and buffers them in a FIFO.
- Each packet is then dispatched either to the router's PE input channel or to a local loopback port.
- It is the transmit end of the router's packet format. The router never routes a P-input packet back to its own P output, so self-addressed packets are resolved here instead.

Parameters:
- WIDTH, 31, total packet width; payload width PW = WIDTH-8.
- XADDR, 2'd0, X coordinate of this node; written into the Xsrc header field.
- YADDR, 2'd0, Y coordinate of this node; written into the Ysrc header field.
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.
- CNT_W, 16, width of the sent-packet counters.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  PE request valid.
- in_ready  out  1  injector can accept a request.
- in_xdest  in  2  destination X.
- in_ydest  in  2  destination Y.
- in_payload  in  PW  payload bits.
- net_valid  out  1  packet valid toward the router PE input (through the async bridge).
- net_ready  in  1  router side accepts.
- net_pkt  out  WIDTH  packet toward the router.
- loop_valid  out  1  self-addressed packet valid toward the local PE.
- loop_ready  in  1  local PE accepts.
- loop_pkt  out  WIDTH  self-addressed packet.
- net_cnt  out  CNT_W  packets delivered on the net port.
- loop_cnt  out  CNT_W  packets delivered on the loop port.

Behaviour:
- Packet format:
  - [30:29] = XADDR
  - [28:27] = YADDR
  - [26:25] = in_xdest
  - [24:23] = in_ydest
  - [22:0] = in_payload
  - The header is built at enqueue time and stored whole in the FIFO.
- Reset behaviour: reset is synchronous. While rst=1 at a clock edge, the following are cleared: FIFO pointers, occupancy count, net_valid, loop_valid, in_ready, net_cnt and loop_cnt. net_pkt and loop_pkt are forced to 0. in_ready rises the cycle after rst deasserts.
- Reset mid-operation: rst discards all queued and in-flight packets. No partial handshake may complete in the reset cycle.
- Ingress:
  - in_ready = (count != DEPTH), registered.
  - Enqueue occurs on a clock edge where in_valid && in_ready.
  - When full, in_ready=0 even if a dequeue happens in the same cycle. Space becomes visible the next cycle.
- Output register and FSM. States:
  - IDLE: the output register is empty.
    - If FIFO non-empty, pop the head into the output register and go to SEND.
    - A packet enqueued at edge N into an empty FIFO is popped at edge N+1, so valid is seen after N+1. Fixed latency: 2 edges.
  - SEND: exactly one of net_valid / loop_valid is high.
    - Selection: loop if pkt[26:25]==XADDR and pkt[24:23]==YADDR; otherwise net.
    - The packet and valid stay stable until the matching ready is sampled high.
    - On acceptance, increment the matching counter. Counters wrap modulo 2^CNT_W with no saturation.
    - After acceptance: if the FIFO is non-empty, pop the next head in the same edge and stay in SEND (back-to-back, one packet per cycle). Otherwise go to IDLE and drop valid.
- Ordering: strict FIFO order across both ports. A stalled loop head blocks net packets behind it and vice versa; no reordering.
- Simultaneous enqueue and pop on the same edge is legal when not full. Count is unchanged.
- Enqueue into an empty FIFO while in IDLE must not bypass the register. The 2-edge latency holds.
- Ready without valid has no effect. The unselected port's ready is ignored.
- Pointer arithmetic: pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Assertions for verification:
  - net_valid and loop_valid never both high.
  - *_pkt is stable while *_valid && !*_ready.
  - count never exceeds DEPTH.

Test Plan:
- Basic net path: XADDR=1, YADDR=2; inject xdest=3, ydest=0, payload=23'h00ABC, net_ready=1 -> net_valid two edges after enqueue, net_pkt=31'b01_10_11_00_000...ABC, net_cnt=1, loop_valid stays 0.
- Loopback: XADDR=1, YADDR=2; inject xdest=1, ydest=2 -> loop_valid=1 with pkt[26:23]=4'b0110, net_valid=0; after loop_ready, loop_cnt=1.
- Full and backpressure: DEPTH=4, net_ready=0; push 6 requests -> 4 in FIFO plus 1 in the output register. in_ready=0 after the 5th accept. Then raise net_ready -> 5 packets emerge in order, one per cycle, and in_ready returns to 1.
- Head-of-line ordering: queue net A, loop B, net C; hold loop_ready=0 -> C not presented until B is accepted. Output order is A, B, C.
- Mid-stream reset: 3 packets queued, assert rst for 1 cycle -> next cycle all valids=0, counters=0, in_ready=0, and no queued packet ever appears. in_ready=1 on the following cycle.
- Counter wrap: CNT_W=4; send 17 net packets -> net_cnt=1.
